uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: idle-high line, 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Sits directly downstream of the io_interface UART transmitter. Consumes a serial line such as uart_tx and delivers parallel bytes with a one-cycle valid strobe.
- Used for loopback verification of the TX path and as the host-to-board command input.

Parameters:
- CLKS_PER_BIT, 434, clocks per bit period (50 MHz / 115200 baud). Legal values are ≥ 4. The bench uses 16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly framed byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx_busy  output  1  high from detected start edge until return to IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, all counters 0
  - rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0
  - both synchronizer FFs=1 (line idle)
- Synchronizer:
  - rx passes through 2 flip-flops to produce rx_s. All decisions use rx_s only.
  - Input-to-decision latency is 2 clocks.
- Counters:
  - Bit-clock counter width is $clog2(CLKS_PER_BIT).
  - HALF = CLKS_PER_BIT/2 (integer division).
  - Bit index is 3 bits.
- State machine:
  - IDLE:
    - rx_busy=0.
    - When rx_s==0, go to START, clear the counter, and set rx_busy=1 on the same edge.
  - START:
    - Count to HALF-1. At that count, sample rx_s (mid start bit).
    - rx_s==1: false start/glitch. Go to IDLE, rx_busy=0, no flags.
    - rx_s==0: go to DATA, clear the counter and bit index.
  - DATA:
    - Each time the counter reaches CLKS_PER_BIT-1, sample rx_s into shift[bit index], clear the counter, and increment the index.
    - After index 7 is sampled, go to STOP.
    - Samples land at mid-bit: HALF + k*CLKS_PER_BIT clocks after the start edge.
  - STOP:
    - At count CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: next edge loads rx_data=shift, rx_valid=1 for exactly one cycle, frame_err=0. Go to IDLE.
      - This returns to IDLE half a bit early, so a back-to-back start edge is caught.
    - rx_s==0: frame_err=1 for one cycle, rx_data unchanged, no rx_valid. Go to BREAK.
  - BREAK:
    - rx_busy stays 1. Wait for rx_s==1, then go to IDLE.
    - Covers a held-low line or break condition; no new frame starts while the line is low.
- Strobe rules:
  - rx_valid and frame_err are never high together.
  - Each pulses at most once per frame and is never high in IDLE except on the edge that leaves STOP.
- Data retention: rx_data changes only on a good frame and otherwise holds indefinitely. There is no overrun detection; the consumer must take the byte within one frame time.
- Reset mid-frame: everything returns to reset values immediately.
  - If rst_n is released while rx is low, the synchronizer loads 1. A falling edge inside the frame may then start a spurious receive.
  - Requirement: a spurious receive may end in a frame error or a discarded frame, but must never produce rx_valid with a framing-correct appearance unless the line really carries one.
- Back-to-back frames with zero idle bits between stop and next start must all be received correctly.

Test Plan:
- Reset, then hold rx=1 for 100 clocks:
  - rx_busy, rx_valid and frame_err stay 0; rx_data=8'h00.
- Loopback from io_interface uart_tx, CLKS_PER_BIT=16, send 0x55 then 0xA7 (5-clock gap):
  - exactly two rx_valid pulses, rx_data=8'h55 then 8'hA7
  - each pulse within 1 clock after the stop-bit mid-sample (~2+HALF+9*16 clocks after the start edge)
  - frame_err never set.
- Drive 0x3C and 0xF0 back-to-back, stop bit directly followed by start bit:
  - both bytes received, two rx_valid pulses about 160 clocks apart.
- Glitch rx=0 for 4 clocks (< HALF=8), then high:
  - START aborts, rx_busy returns to 0 within 12 clocks, no rx_valid, no frame_err.
- Frame 0x81 with stop bit driven 0, held low 50 more clocks, then high:
  - one frame_err pulse, no rx_valid, rx_data keeps its prior value
  - rx_busy stays high until rx returns high, then 0
  - a following 0x12 frame is received correctly.
- Assert rst_n=0 during data bit 4 of a frame, release after 3 clocks with rx=1, then send 0x6B:
  - outputs go to reset values immediately; no stale byte or flag.
  - 0x6B is received with one rx_valid pulse.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling, one-cycle
// rx_valid / frame_err strobes and a break-wait state after a bad stop bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int unsigned   CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;

  // Synchronizer resets to the idle level so a reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random serial traffic checked every cycle
// against a frame-timing model plus a list of bytes the stimulus intends to deliver.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Written only by the stimulus process.
  logic [7:0] lit_exp [0:255];
  int         lit_wr   = 0;
  int         exp_ferr = 0;
  bit         done     = 1'b0;

  // Written only by the compare process.
  int         vectors     = 0;
  int         miscompares = 0;
  int         n           = 0;
  int         dlit_rd     = 0;
  int         mlit_rd     = 0;
  int         dut_valid_cnt = 0;
  int         dut_ferr_cnt  = 0;
  logic       m_d1, m_d2, rxs;
  int         m_t0, d;
  bit         m_brk;
  logic [7:0] m_bits, m_data;
  logic       m_valid, m_ferr, m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  // Model: a frame is a window of absolute cycle offsets from the detected start edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_d1 = 1'b1; m_d2 = 1'b1; m_t0 = -1; m_brk = 1'b0;
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_bits = 8'h00;
      end else begin
        n++;
        rxs  = m_d2;
        m_d2 = m_d1;
        m_d1 = rx;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (m_t0 >= 0) begin
          d = n - m_t0;
          if (d == HALF) begin
            if (rxs) m_t0 = -1;
          end else if (d > HALF && d < HALF + 9*CPB && (d - HALF) % CPB == 0) begin
            m_bits[(d - HALF) / CPB - 1] = rxs;
          end else if (d == HALF + 9*CPB) begin
            if (rxs) begin
              m_data  = m_bits;
              m_valid = 1'b1;
            end else begin
              m_ferr = 1'b1;
              m_brk  = 1'b1;
            end
            m_t0 = -1;
          end
        end else if (m_brk) begin
          if (rxs) m_brk = 1'b0;
        end else if (!rxs) begin
          m_t0 = n;
        end
      end
      m_busy = (m_t0 >= 0) || m_brk;
      #1;
      if (!rst_n) begin
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_busy", {31'd0, rx_busy}, 32'h0);
      end
      chk("rx_valid",  {31'd0, rx_valid},  {31'd0, m_valid});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      chk("rx_busy",   {31'd0, rx_busy},   {31'd0, m_busy});
      chk("rx_data",   {24'd0, rx_data},   {24'd0, m_data});
      if (m_valid) begin
        if (mlit_rd < lit_wr) chk("model_byte", {24'd0, m_data}, {24'd0, lit_exp[mlit_rd]});
        else                  chk("model_extra_valid", mlit_rd, lit_wr);
        mlit_rd++;
      end
      if (rx_valid === 1'b1) begin
        dut_valid_cnt++;
        if (dlit_rd < lit_wr) chk("dut_byte", {24'd0, rx_data}, {24'd0, lit_exp[dlit_rd]});
        else                  chk("dut_extra_valid", dlit_rd, lit_wr);
        dlit_rd++;
      end
      if (frame_err === 1'b1) dut_ferr_cnt++;
      if (done && rst_n) begin
        chk("valid_count", dut_valid_cnt, lit_wr);
        chk("ferr_count", dut_ferr_cnt, exp_ferr);
        chk("model_last_byte", {24'd0, m_data}, {24'd0, lit_exp[lit_wr-1]});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  task automatic hold(input logic v, input int cyc);
    rx = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    if (stop_v) begin
      lit_exp[lit_wr] = b;
      lit_wr++;
    end else begin
      exp_ferr++;
    end
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_v, CPB);
  endtask

  initial begin
    logic [7:0] partial;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 100);

    send(8'h55, 1'b1);
    hold(1'b1, 5);
    send(8'hA7, 1'b1);
    hold(1'b1, 20);

    send(8'h3C, 1'b1);
    send(8'hF0, 1'b1);
    hold(1'b1, 20);

    hold(1'b0, 4);
    hold(1'b1, 30);

    send(8'h81, 1'b0);
    hold(1'b0, 50);
    hold(1'b1, 20);
    send(8'h12, 1'b1);
    hold(1'b1, 20);

    // Abort a frame with reset during data bit 4; this byte must never appear.
    partial = 8'h5A;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(partial[i], CPB);
    hold(partial[4], HALF);
    rst_n = 1'b0;
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 20);
    send(8'h6B, 1'b1);
    hold(1'b1, 20);

    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        hold(1'b0, int'($urandom_range(1, 6)));
        hold(1'b1, 20);
      end else if (kind == 1) begin
        send(8'($urandom), 1'b0);
        hold(1'b0, int'($urandom_range(0, 40)));
        hold(1'b1, 2*CPB);
      end else begin
        send(8'($urandom), 1'b1);
        if ($urandom_range(0, 2) != 0) hold(1'b1, int'($urandom_range(1, 20)));
      end
    end
    hold(1'b1, 3*CPB);
    done = 1'b1;
    hold(1'b1, 5);
  end

endmodule
